// File: rtl/flash_arbiter_if.sv
// Requester and Avalon-MM flash signals shared by flash_arbiter and its environment.
// master: the arbiter side; slave: the requesters plus the flash device.
interface flash_arbiter_if;
  localparam int unsigned AW = 23;
  localparam int unsigned DW = 32;

  logic          r0_req;
  logic [AW-1:0] r0_addr;
  logic          r0_ack;
  logic [DW-1:0] r0_rdata;
  logic          r0_rvalid;
  logic          r0_err;

  logic          r1_req;
  logic [AW-1:0] r1_addr;
  logic          r1_ack;
  logic [DW-1:0] r1_rdata;
  logic          r1_rvalid;
  logic          r1_err;

  logic          flash_mem_read;
  logic [AW-1:0] flash_mem_address;
  logic          flash_mem_waitrequest;
  logic [DW-1:0] flash_mem_readdata;
  logic          flash_mem_readdatavalid;
  logic          flash_mem_write;
  logic [6:0]    flash_mem_burstcount;
  logic [3:0]    flash_mem_byteenable;
  logic [DW-1:0] flash_mem_writedata;

  logic          busy;

  modport master (
    input  r0_req, r0_addr, r1_req, r1_addr,
    input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
    output r0_ack, r0_rdata, r0_rvalid, r0_err,
    output r1_ack, r1_rdata, r1_rvalid, r1_err,
    output flash_mem_read, flash_mem_address, flash_mem_write,
    output flash_mem_burstcount, flash_mem_byteenable, flash_mem_writedata,
    output busy
  );

  modport slave (
    output r0_req, r0_addr, r1_req, r1_addr,
    output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
    input  r0_ack, r0_rdata, r0_rvalid, r0_err,
    input  r1_ack, r1_rdata, r1_rvalid, r1_err,
    input  flash_mem_read, flash_mem_address, flash_mem_write,
    input  flash_mem_burstcount, flash_mem_byteenable, flash_mem_writedata,
    input  busy
  );
endinterface

// File: rtl/flash_arbiter.sv
// Two-port round-robin arbiter running one single-word Avalon-MM flash read per grant,
// with a watchdog that aborts reads the flash never completes.
module flash_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  flash_arbiter_if.master bus
);
  localparam int unsigned AW = 23;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, RESP} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;     // current owner, doubles as last_grant
  logic [CW-1:0] cnt_q, cnt_d;
  logic          read_q, read_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [1:0]    err_q, err_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          busy_q;
  logic          grant_c;
  logic          timeout_c;

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b1;
      cnt_q    <= '0;
      read_q   <= 1'b0;
      addr_q   <= '0;
      ack_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    read_d    = read_q;
    addr_d    = addr_q;
    ack_d     = '0;
    rvalid_d  = '0;
    err_d     = '0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    grant_c   = 1'b0;
    timeout_c = (cnt_q == TO_LAST);

    case (state_q)
      IDLE: begin
        // A tie goes to the port that was not served last
        grant_c = (bus.r0_req && bus.r1_req) ? ~owner_q : bus.r1_req;
        if (bus.r0_req || bus.r1_req) begin
          owner_d        = grant_c;
          addr_d         = grant_c ? bus.r1_addr : bus.r0_addr;
          read_d         = 1'b1;
          cnt_d          = '0;
          ack_d[grant_c] = 1'b1;
          state_d        = ISSUE;
        end
      end

      ISSUE, WAIT_DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (timeout_c) begin
          read_d            = 1'b0;
          rvalid_d[owner_q] = 1'b1;
          err_d[owner_q]    = 1'b1;
          if (owner_q) rdata1_d = '0;
          else         rdata0_d = '0;
          state_d           = RESP;
        end else if (state_q == ISSUE) begin
          if (!bus.flash_mem_waitrequest) begin
            read_d  = 1'b0;
            state_d = WAIT_DATA;
          end
        end else if (bus.flash_mem_readdatavalid) begin
          rvalid_d[owner_q] = 1'b1;
          if (owner_q) rdata1_d = bus.flash_mem_readdata;
          else         rdata0_d = bus.flash_mem_readdata;
          state_d           = RESP;
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.r0_ack    = ack_q[0];
  assign bus.r0_rvalid = rvalid_q[0];
  assign bus.r0_err    = err_q[0];
  assign bus.r0_rdata  = rdata0_q;
  assign bus.r1_ack    = ack_q[1];
  assign bus.r1_rvalid = rvalid_q[1];
  assign bus.r1_err    = err_q[1];
  assign bus.r1_rdata  = rdata1_q;

  assign bus.flash_mem_read       = read_q;
  assign bus.flash_mem_address    = addr_q;
  assign bus.flash_mem_write      = 1'b0;
  assign bus.flash_mem_burstcount = 7'd1;
  assign bus.flash_mem_byteenable = 4'hF;
  assign bus.flash_mem_writedata  = '0;
  assign bus.busy                 = busy_q;
endmodule

// File: tb/tb_flash_arbiter.sv
// Directed and randomized checks of flash_arbiter against a transaction-level model
// of the arbitration, latency and timeout rules, driven through a behavioural flash.
module tb_flash_arbiter;
  localparam int unsigned TO_CYC = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  int          exp_last = 1;
  logic [31:0] exp_rdata [2] = '{32'h0, 32'h0};

  // Flash behaviour knobs
  int          fl_wait  = 0;
  int          fl_dlat  = 0;
  bit          fl_stuck = 1'b0;
  logic [31:0] fl_data  = 32'h0;

  flash_arbiter_if bus ();

  flash_arbiter #(.TIMEOUT(TO_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural flash: waitrequest held for fl_wait samples, data fl_dlat samples after accept
  initial begin
    int hold = 0;
    int cnt = 0;
    bit armed = 1'b0;
    bit pend = 1'b0;
    bus.flash_mem_waitrequest   = 1'b1;
    bus.flash_mem_readdatavalid = 1'b0;
    bus.flash_mem_readdata      = 32'h0;
    forever begin
      @(negedge clk);
      bus.flash_mem_readdatavalid = 1'b0;
      bus.flash_mem_readdata      = $urandom;
      if (bus.flash_mem_read) begin
        bus.flash_mem_waitrequest = fl_stuck || (hold < fl_wait);
        hold++;
        armed = !bus.flash_mem_waitrequest;
      end else begin
        bus.flash_mem_waitrequest = 1'b1;
        hold = 0;
        if (armed) begin
          armed = 1'b0;
          pend  = 1'b1;
          cnt   = fl_dlat;
        end
      end
      if (pend) begin
        if (cnt == 0) begin
          bus.flash_mem_readdatavalid = 1'b1;
          bus.flash_mem_readdata      = fl_data;
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p != 0) ? bus.r1_ack : bus.r0_ack;
  endfunction
  function automatic logic rvalid_of(input int p);
    return (p != 0) ? bus.r1_rvalid : bus.r0_rvalid;
  endfunction
  function automatic logic err_of(input int p);
    return (p != 0) ? bus.r1_err : bus.r0_err;
  endfunction
  function automatic logic [31:0] rdata_of(input int p);
    return (p != 0) ? bus.r1_rdata : bus.r0_rdata;
  endfunction
  function automatic logic req_of(input int p);
    return (p != 0) ? bus.r1_req : bus.r0_req;
  endfunction
  function automatic logic [22:0] addr_of(input int p);
    return (p != 0) ? bus.r1_addr : bus.r0_addr;
  endfunction

  task automatic set_req(input int p, input logic v);
    if (p != 0) bus.r1_req = v;
    else        bus.r0_req = v;
  endtask
  task automatic set_addr(input int p, input logic [22:0] a);
    if (p != 0) bus.r1_addr = a;
    else        bus.r0_addr = a;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_acks"},   32'({bus.r0_ack, bus.r1_ack}), 32'h0);
    chk({tag, "_rvalid"}, 32'({bus.r0_rvalid, bus.r1_rvalid, bus.r0_err, bus.r1_err}), 32'h0);
    chk({tag, "_rdata0"}, bus.r0_rdata, 32'h0);
    chk({tag, "_rdata1"}, bus.r1_rdata, 32'h0);
    chk({tag, "_read"},   32'({bus.flash_mem_read, bus.busy}), 32'h0);
    chk({tag, "_addr"},   32'(bus.flash_mem_address), 32'h0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    exp_last     = 1;
    exp_rdata[0] = 32'h0;
    exp_rdata[1] = 32'h0;
  endtask

  // One full transaction on `port`, called at a negedge while the DUT is idle
  task automatic run_txn(input int port, input logic [31:0] data, input bit to,
                         input int lat, input int rd_cyc, input bit keep, input bit glitch);
    int n;
    int rdcnt;
    int other;
    bit got;
    logic [22:0] exp_addr;
    logic [31:0] exp_d;
    other    = 1 - port;
    exp_addr = addr_of(port);
    exp_d    = to ? 32'h0 : data;
    fl_data  = data;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = bus.r0_ack | bus.r1_ack;
    end
    chk("ack_wait",  32'(n), 32'd1);
    chk("ack_own",   32'(ack_of(port)), 32'd1);
    chk("ack_other", 32'(ack_of(other)), 32'd0);
    chk("issue_addr", 32'(bus.flash_mem_address), 32'(exp_addr));
    chk("busy_grant", 32'(bus.busy), 32'd1);
    rdcnt = bus.flash_mem_read ? 1 : 0;
    if (!keep) set_req(port, 1'b0);
    if (glitch) begin
      set_addr(other, 23'h5A5A5);
      set_req(other, 1'b1);
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (glitch && n == 1) set_req(other, 1'b0);
      if (bus.flash_mem_read) begin
        rdcnt++;
        chk("addr_hold", 32'(bus.flash_mem_address), 32'(exp_addr));
      end
      chk("ack_once",    32'({bus.r0_ack, bus.r1_ack}), 32'h0);
      chk("other_quiet", 32'({rvalid_of(other), err_of(other)}), 32'h0);
      chk("other_rdata", rdata_of(other), exp_rdata[other]);
      chk("busy_txn",    32'(bus.busy), 32'd1);
      got = rvalid_of(port);
    end
    chk("latency",     32'(n), 32'(lat));
    chk("rdata",       rdata_of(port), exp_d);
    chk("err",         32'(err_of(port)), 32'(to));
    chk("read_cycles", 32'(rdcnt), 32'(rd_cyc));
    exp_rdata[port] = exp_d;
    exp_last        = port;
    @(negedge clk);
    chk("resp_end",   32'({bus.busy, rvalid_of(port), err_of(port), bus.r0_ack, bus.r1_ack,
                           bus.flash_mem_read}), 32'h0);
    chk("rdata_hold", rdata_of(port), exp_rdata[port]);
  endtask

  initial begin
    int p;
    int w;
    int d;
    bus.r0_req  = 1'b0;
    bus.r1_req  = 1'b0;
    bus.r0_addr = '0;
    bus.r1_addr = '0;

    // Reset state and constant Avalon outputs
    reset_dut();
    chk("const_write", 32'(bus.flash_mem_write), 32'd0);
    chk("const_burst", 32'(bus.flash_mem_burstcount), 32'd1);
    chk("const_be",    32'(bus.flash_mem_byteenable), 32'hF);
    chk("const_wdata", bus.flash_mem_writedata, 32'h0);

    // Single read on port 0, minimum-latency flash
    fl_wait = 0;
    fl_dlat = 0;
    set_addr(0, 23'h10);
    set_req(0, 1'b1);
    run_txn(0, 32'hDEADBEEF, 1'b0, 2, 1, 1'b0, 1'b0);

    // Tie after reset: port 0 first, then strict alternation
    reset_dut();
    set_addr(0, 23'd5);
    set_addr(1, 23'd9);
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run_txn(i % 2, $urandom, 1'b0, 2, 1, 1'b1, 1'b0);
    end
    set_req(0, 1'b0);
    set_req(1, 1'b0);

    // Port 1 held for four back-to-back reads of an incrementing flash
    set_addr(1, 23'h40);
    set_req(1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_txn(1, 32'(i + 1), 1'b0, 2, 1, 1'b1, 1'b0);
    end
    set_req(1, 1'b0);

    // Flash lowering waitrequest one cycle late: rvalid 3 edges after grant
    fl_wait = 1;
    set_addr(0, 23'h1234);
    set_req(0, 1'b1);
    run_txn(0, 32'hCAFE0001, 1'b0, 3, 2, 1'b0, 1'b0);

    // A port-1 request raised and dropped mid-transaction is forgotten
    fl_wait = 3;
    fl_dlat = 2;
    set_addr(0, 23'h777);
    set_req(0, 1'b1);
    run_txn(0, 32'h0BADF00D, 1'b0, 7, 4, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("no_memory", 32'({bus.r0_ack, bus.r1_ack, bus.busy}), 32'h0);
    end

    // Watchdog abort with waitrequest stuck high
    fl_stuck = 1'b1;
    set_addr(0, 23'h2A);
    set_req(0, 1'b1);
    run_txn(0, 32'hFFFF_FFFF, 1'b1, int'(TO_CYC), int'(TO_CYC), 1'b0, 1'b0);
    fl_stuck = 1'b0;

    // Reset during WAIT_DATA; the late readdatavalid must be ignored
    fl_wait = 0;
    fl_dlat = 6;
    fl_data = 32'h5555AAAA;
    set_addr(0, 23'h77);
    set_req(0, 1'b1);
    @(negedge clk);
    chk("mid_ack", 32'(bus.r0_ack), 32'd1);
    set_req(0, 1'b0);
    @(negedge clk);
    chk("mid_waitdata", 32'({bus.busy, bus.flash_mem_read}), 32'b10);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    exp_last     = 1;
    exp_rdata[0] = 32'h0;
    exp_rdata[1] = 32'h0;
    repeat (10) begin
      @(negedge clk);
      chk("late_rdv", 32'({bus.r0_rvalid, bus.r1_rvalid, bus.busy}), 32'h0);
    end
    fl_dlat = 0;
    set_addr(0, 23'h100);
    set_addr(1, 23'h200);
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    run_txn(0, 32'h00C0FFEE, 1'b0, 2, 1, 1'b0, 1'b0);
    run_txn(1, 32'h00FACADE, 1'b0, 2, 1, 1'b0, 1'b0);

    // Randomized requests and flash latencies against the round-robin model
    for (int t = 0; t < 40; t++) begin
      for (int q = 0; q < 2; q++) begin
        if (!req_of(q) && ($urandom_range(0, 1) != 0)) begin
          set_addr(q, 23'($urandom));
          set_req(q, 1'b1);
        end
      end
      if (!bus.r0_req && !bus.r1_req) begin
        set_addr(0, 23'($urandom));
        set_req(0, 1'b1);
      end
      w = int'($urandom_range(0, 3));
      d = int'($urandom_range(0, 3));
      fl_wait = w;
      fl_dlat = d;
      if (bus.r0_req && bus.r1_req) p = 1 - exp_last;
      else                          p = bus.r1_req ? 1 : 0;
      run_txn(p, $urandom, 1'b0, 2 + w + d, w + 1, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/flash_arbiter.md
# flash_arbiter

- Two-port round-robin read arbiter that shares the single Avalon-MM flash master port between two requesters.
- Typical requesters: the audio sample fetcher and the sample-RAM loader.
- Each grant runs exactly one single-word read: command issue, waitrequest handshake, readdatavalid capture, and a one-cycle response pulse back to the owning requester.
- A watchdog aborts reads that the flash never completes.

## Interface
Parameters:
- TIMEOUT, default 255: cycles allowed in ISSUE+WAIT_DATA before abort (1..65535).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset: asynchronous, active-high.
- r0_req  in  1  requester 0 read request; held high until r0_ack.
- r0_addr  in  23  requester 0 word address; sampled on grant.
- r0_ack  out  1  one-cycle pulse: request 0 granted and address latched.
- r0_rdata  out  32  requester 0 read data; valid when r0_rvalid=1.
- r0_rvalid  out  1  one-cycle pulse: r0_rdata valid.
- r0_err  out  1  one-cycle pulse coincident with r0_rvalid on timeout.
- r1_req, r1_addr, r1_ack, r1_rdata, r1_rvalid, r1_err: same as port 0, for requester 1.
- flash_mem_read  out  1  Avalon read command.
- flash_mem_address  out  23  Avalon word address.
- flash_mem_waitrequest  in  1  Avalon waitrequest.
- flash_mem_readdata  in  32  Avalon read data.
- flash_mem_readdatavalid  in  1  Avalon read data valid.
- flash_mem_write  out  1  constant 0.
- flash_mem_burstcount  out  7  constant 7'd1.
- flash_mem_byteenable  out  4  constant 4'hF.
- flash_mem_writedata  out  32  constant 0.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
States: IDLE, ISSUE, WAIT_DATA, RESP.

**IDLE**
- Arbitration happens only in this state.
- If exactly one req is high, grant that port.
- If both are high, grant the port ≠ last_grant.
- On grant: latch owner and address, drive flash_mem_read=1 and flash_mem_address=rN_addr, pulse rN_ack, clear the timeout counter, set last_grant=owner, go to ISSUE.

**ISSUE**
- Hold read=1 and the address stable.
- On an edge that samples waitrequest=0: read←0, go to WAIT_DATA.

**WAIT_DATA**
- On an edge that samples readdatavalid=1: owner rdata←flash_mem_readdata, owner rvalid←1, go to RESP.
- readdatavalid sampled in IDLE or ISSUE is ignored.

**RESP**
- Lasts one cycle: rvalid/err ←0, go to IDLE.

**Timeout**
- The counter increments every cycle in ISSUE or WAIT_DATA.
- When it reaches TIMEOUT: read←0, owner rdata←0, owner rvalid←1, owner err←1, go to RESP.
- Timeout takes priority over a same-edge waitrequest=0 or readdatavalid=1.

**Other rules**
- The non-owner's outputs never change during a transaction.
- rN_rdata holds its last value until the next response to that port.
- A req that drops before ack is not remembered.
- A req held high after its own ack starts a new transaction on a later IDLE.

## Timing
- Reset (async, any state):
  - state=IDLE, last_grant=1 (so port 0 wins the first tie).
  - Timeout counter=0.
  - All ack/rvalid/err=0, rdata=0, flash_mem_read=0, flash_mem_address=0, busy=0.
  - An in-flight flash read is abandoned; its late readdatavalid is ignored.
- All outputs are registered.
- ack is high for exactly the cycle following the IDLE edge that granted.
- Minimum latency, measured in edges after the grant edge:
  - waitrequest low on first sample: read accepted at +1.
  - readdatavalid on the next edge: rvalid high after +2.
  - IDLE re-entered after +3.
- Against a flash that lowers waitrequest one cycle after seeing read and raises readdatavalid one cycle later: rvalid is high after edge +3.
- The next grant can occur at the first IDLE edge, i.e. one cycle after RESP.
- Back-to-back requests are never pipelined: one outstanding read maximum.

## Test plan
- **Single read, port 0:** r0_req=1, r0_addr=23'h10; flash returns 32'hDEADBEEF. Required:
  - r0_ack pulses once.
  - flash_mem_address=23'h10 while read=1.
  - r0_rvalid pulses once with r0_rdata=32'hDEADBEEF.
  - r0_err=0; r1 outputs unchanged.
- **Tie after reset:** both req high with addr0=5, addr1=9. Required:
  - Port 0 is served first (address 5), then port 1 (address 9).
  - Strict alternation continues for 8 transactions.
- **Port 1 only, repeated:** r1_req held high for 4 reads of an incrementing flash model. Required: 4 r1_rvalid pulses with data 1,2,3,4, no gaps longer than the one RESP+IDLE overhead.
- **Timeout:** TIMEOUT=20, waitrequest stuck at 1. Required:
  - read stays high for 20 cycles, then drops.
  - r0_rvalid=1 with r0_err=1 and r0_rdata=0.
  - State returns to IDLE.
- **Reset mid-read:** assert rst while in WAIT_DATA. Required:
  - All outputs are 0 immediately.
  - A readdatavalid arriving after reset release produces no rvalid.
  - The next tie grants port 0.
- **Latency check with the one-cycle-waitrequest flash model:** r0_rvalid is high exactly 3 edges after the grant edge; busy stays high from the grant edge until RESP ends.
